riscv_v_reduct_ctrl: RTL and testbench

//  Sequences the multi-pass vector reduction datapath: one request = one reduction instruction.

---
 rtl/riscv_v_pkg.sv | 37 +++
 rtl/riscv_v_onehot2idx.sv | 29 ++
 rtl/riscv_v_reduct_ctrl.sv | 171 +++++++++++++++++
 tb/tb_riscv_v_reduct_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_v_pkg.sv
// Shared types and helpers for the vector unit control slice.
package riscv_v_pkg;

  localparam int RISCV_V_DATA_WIDTH       = 128;
  localparam int RISCV_V_NUM_VALID_OSIZES = 5;
  localparam int RISCV_V_PASS_W           = $clog2(RISCV_V_NUM_VALID_OSIZES);

  typedef logic [RISCV_V_NUM_VALID_OSIZES-1:0] osize_vector_t;
  typedef logic [RISCV_V_DATA_WIDTH-1:0]       riscv_v_data_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } riscv_v_reduct_state_e;

  // One-hot osize vector with only bit idx set.
  function automatic osize_vector_t osize_onehot(input int idx);
    osize_vector_t v;
    v = '0;
    for (int i = 0; i < RISCV_V_NUM_VALID_OSIZES; i++) begin
      if (i == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Mask of every osize strictly wider than idx.
  function automatic osize_vector_t osize_greater(input int idx);
    osize_vector_t v;
    v = '0;
    for (int i = 0; i < RISCV_V_NUM_VALID_OSIZES; i++) begin
      if (i > idx) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/riscv_v_onehot2idx.sv
// One-hot osize vector to binary index, with a flag that is set only when
// exactly one bit is set.
module riscv_v_onehot2idx
  import riscv_v_pkg::*;
#(
  parameter int N = RISCV_V_NUM_VALID_OSIZES,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  int unsigned ones;

  // OR together the indices of all set bits and count them.
  always_comb begin
    idx_o = '0;
    ones  = 0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        idx_o = idx_o | W'(i);
        ones  = ones + 1;
      end
    end
    valid_o = (ones == 1);
  end

endmodule

// File: rtl/riscv_v_reduct_ctrl.sv
// Multi-pass vector reduction sequencer. Folds the operand from the widest
// element size down to the requested SEW, one ALU pass per size step, and
// returns the accumulator on a valid/ready port.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request, in_ready high
//   ISSUE | running passes; alu_req held until ack, 1-cycle gap between
//   DONE  | result held on out_data until out_ready
module riscv_v_reduct_ctrl
  import riscv_v_pkg::*;
#(
  parameter int NUM_OSIZES = RISCV_V_NUM_VALID_OSIZES,
  parameter int PASS_W     = $clog2(NUM_OSIZES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  osize_vector_t in_osize,
  input  riscv_v_data_t in_src,
  output logic          alu_req,
  input  logic          alu_ack,
  input  riscv_v_data_t alu_result,
  output riscv_v_data_t src_o,
  output riscv_v_data_t result_o,
  output logic          is_reduct,
  output logic          is_reduct_n,
  output osize_vector_t osize_vector,
  output osize_vector_t is_greater_osize_vector,
  output logic          out_valid,
  input  logic          out_ready,
  output riscv_v_data_t out_data,
  output logic          err
);

  riscv_v_reduct_state_e state_q, state_d;
  logic [PASS_W-1:0]     pass_q, pass_d;
  logic [PASS_W-1:0]     sew_q, sew_d;
  logic                  first_q, first_d;
  riscv_v_data_t         src_q, src_d;
  riscv_v_data_t         acc_q, acc_d;
  logic                  alu_req_q, alu_req_d;
  logic                  err_q, err_d;
  osize_vector_t         osize_q, osize_d;
  osize_vector_t         greater_q, greater_d;
  logic                  is_reduct_q, is_reduct_d;
  logic                  is_reduct_n_q;

  logic [PASS_W-1:0]     sew_idx;
  logic                  osize_ok;

  riscv_v_onehot2idx #(
    .N (NUM_OSIZES),
    .W (PASS_W)
  ) u_onehot2idx (
    .vec_i   (in_osize),
    .idx_o   (sew_idx),
    .valid_o (osize_ok)
  );

  // Next-state, pass counter, accumulator and registered control outputs.
  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    sew_d     = sew_q;
    first_d   = first_q;
    src_d     = src_q;
    acc_d     = acc_q;
    alu_req_d = 1'b0;
    err_d     = 1'b0;
    osize_d   = osize_q;
    greater_d = greater_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d  = in_src;
          sew_d  = sew_idx;
          pass_d = PASS_W'(NUM_OSIZES - 2);
          if (!osize_ok) begin
            // Malformed SEW: flag it but still complete with the operand untouched.
            err_d   = 1'b1;
            acc_d   = in_src;
            state_d = DONE;
          end else if (sew_idx == PASS_W'(NUM_OSIZES - 1)) begin
            // Full-width SEW needs no folding.
            acc_d   = in_src;
            state_d = DONE;
          end else begin
            state_d   = ISSUE;
            first_d   = 1'b1;
            alu_req_d = 1'b1;
            osize_d   = osize_onehot(NUM_OSIZES - 2);
            greater_d = osize_greater(NUM_OSIZES - 2);
          end
        end
      end
      ISSUE: begin
        if (!alu_req_q) begin
          // Gap cycle after a pass: re-raise the request for the next one.
          alu_req_d = 1'b1;
        end else if (alu_ack) begin
          acc_d   = alu_result;
          first_d = 1'b0;
          if (pass_q == sew_q) begin
            state_d   = DONE;
            osize_d   = '0;
            greater_d = '0;
          end else begin
            pass_d    = pass_q - PASS_W'(1);
            osize_d   = osize_onehot(int'(pass_q) - 1);
            greater_d = osize_greater(int'(pass_q) - 1);
          end
        end else begin
          alu_req_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    is_reduct_d = (state_d == ISSUE) && !first_d;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pass_q        <= '0;
      sew_q         <= '0;
      first_q       <= 1'b0;
      src_q         <= '0;
      acc_q         <= '0;
      alu_req_q     <= 1'b0;
      err_q         <= 1'b0;
      osize_q       <= '0;
      greater_q     <= '0;
      is_reduct_q   <= 1'b0;
      is_reduct_n_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      pass_q        <= pass_d;
      sew_q         <= sew_d;
      first_q       <= first_d;
      src_q         <= src_d;
      acc_q         <= acc_d;
      alu_req_q     <= alu_req_d;
      err_q         <= err_d;
      osize_q       <= osize_d;
      greater_q     <= greater_d;
      is_reduct_q   <= is_reduct_d;
      is_reduct_n_q <= ~is_reduct_d;
    end
  end

  assign in_ready                = (state_q == IDLE);
  assign out_valid               = (state_q == DONE);
  assign out_data                = acc_q;
  assign result_o                = acc_q;
  assign src_o                   = src_q;
  assign alu_req                 = alu_req_q;
  assign err                     = err_q;
  assign osize_vector            = osize_q;
  assign is_greater_osize_vector = greater_q;
  assign is_reduct               = is_reduct_q;
  assign is_reduct_n             = is_reduct_n_q;

endmodule

// File: tb/tb_riscv_v_reduct_ctrl.sv
// Bench for the vector reduction sequencer: directed vector table, a reset
// abort sequence, idle-port noise, then randomized requests.
module tb_riscv_v_reduct_ctrl;
  import riscv_v_pkg::*;

  localparam int NUM = RISCV_V_NUM_VALID_OSIZES;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  osize_vector_t in_osize;
  riscv_v_data_t in_src;
  logic          alu_req;
  logic          alu_ack;
  riscv_v_data_t alu_result;
  riscv_v_data_t src_o;
  riscv_v_data_t result_o;
  logic          is_reduct;
  logic          is_reduct_n;
  osize_vector_t osize_vector;
  osize_vector_t is_greater_osize_vector;
  logic          out_valid;
  logic          out_ready;
  riscv_v_data_t out_data;
  logic          err;

  int checks   = 0;
  int failures = 0;

  riscv_v_reduct_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .in_osize                (in_osize),
    .in_src                  (in_src),
    .alu_req                 (alu_req),
    .alu_ack                 (alu_ack),
    .alu_result              (alu_result),
    .src_o                   (src_o),
    .result_o                (result_o),
    .is_reduct               (is_reduct),
    .is_reduct_n             (is_reduct_n),
    .osize_vector            (osize_vector),
    .is_greater_osize_vector (is_greater_osize_vector),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .out_data                (out_data),
    .err                     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    osize_vector_t osz;
    int            dly;
    int            hold;
    bit            exp_err;
    int            exp_passes;
    int            exp_lat;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic riscv_v_data_t rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: passes run from the widest non-full size down to SEW, each
  // costing (dly+1) request cycles, with a one-cycle gap between passes.
  function automatic void model(input osize_vector_t osz, input int dly,
                                output bit e, output int p, output int lat);
    int ones = 0;
    int sew  = 0;
    for (int i = 0; i < NUM; i++) begin
      if (osz[i]) begin
        ones++;
        sew = i;
      end
    end
    e   = (ones != 1);
    p   = e ? 0 : (NUM - 1 - sew);
    lat = (p == 0) ? 1 : 1 + p * (dly + 1) + (p - 1);
  endfunction

  task automatic do_reduction(input osize_vector_t osz, input riscv_v_data_t src,
                              input int dly, input int hold,
                              input bit exp_err, input int exp_p, input int exp_lat);
    int            cyc;
    int            pass;
    int            reqcnt;
    int            p;
    riscv_v_data_t last_res;
    riscv_v_data_t exp_out;
    osize_vector_t exp_osz;
    osize_vector_t exp_gt;

    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_osize = osz;
    in_src   = src;
    @(negedge clk);
    in_valid = 1'b0;
    in_osize = osize_vector_t'($urandom_range(0, 31));
    in_src   = rand_data();
    cyc      = 1;
    pass     = 0;
    reqcnt   = 0;
    last_res = src;
    check("err_on_accept", err, exp_err);

    while (!out_valid && cyc < 300) begin
      if (cyc > 1) check("err_pulse_width", err, 0);
      if (alu_req) begin
        p       = NUM - 2 - pass;
        exp_osz = '0;
        exp_gt  = '0;
        for (int i = 0; i < NUM; i++) begin
          if (i == p) exp_osz[i] = 1'b1;
          if (i > p)  exp_gt[i]  = 1'b1;
        end
        check("osize_vector", osize_vector, exp_osz);
        check("is_greater", is_greater_osize_vector, exp_gt);
        check("is_reduct", is_reduct, (pass > 0));
        check("is_reduct_n", is_reduct_n, (pass == 0));
        check("src_o", src_o, src);
        if (pass > 0) check("result_o_feedback", result_o, last_res);
        if (reqcnt == dly) begin
          alu_ack    = 1'b1;
          alu_result = rand_data();
          last_res   = alu_result;
          pass++;
          reqcnt     = 0;
        end else begin
          alu_ack = 1'b0;
          reqcnt++;
        end
      end else begin
        alu_ack = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    alu_ack = 1'b0;

    check("done_reached", out_valid, 1);
    check("pass_count", pass, exp_p);
    check("latency", cyc, exp_lat);
    exp_out = (exp_p == 0) ? src : last_res;
    check("out_data", out_data, exp_out);
    check("alu_req_in_done", alu_req, 0);
    check("in_ready_in_done", in_ready, 0);

    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_osize  = 5'b00001;
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_data", out_data, exp_out);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_done", in_ready, 1);
    check("out_valid_after_done", out_valid, 0);
    check("alu_req_after_done", alu_req, 0);
    check("err_after_done", err, 0);
  endtask

  initial begin
    bit            e;
    int            p;
    int            lat;
    int            cyc;
    int            pass;
    bit            seen;
    osize_vector_t osz;
    riscv_v_data_t src;
    riscv_v_data_t keep;
    int            dly;
    int            hold;

    tbl[0] = '{5'b00001, 0, 0, 1'b0, 4, 8};
    tbl[1] = '{5'b01000, 0, 0, 1'b0, 1, 2};
    tbl[2] = '{5'b10000, 0, 0, 1'b0, 0, 1};
    tbl[3] = '{5'b00110, 0, 0, 1'b1, 0, 1};
    tbl[4] = '{5'b00010, 2, 5, 1'b0, 3, 12};
    tbl[5] = '{5'b00000, 0, 1, 1'b1, 0, 1};
    tbl[6] = '{5'b00100, 1, 2, 1'b0, 2, 6};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_osize   = '0;
    in_src     = '0;
    alu_ack    = 1'b0;
    alu_result = '0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_req", alu_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_is_reduct", is_reduct, 0);
    check("rst_is_reduct_n", is_reduct_n, 1);
    check("rst_osize", osize_vector, 0);
    check("rst_greater", is_greater_osize_vector, 0);
    check("rst_src", src_o, 0);
    check("rst_acc", result_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // Stray ack / out_ready while idle must be ignored.
    alu_ack    = 1'b1;
    out_ready  = 1'b1;
    alu_result = rand_data();
    repeat (2) @(negedge clk);
    alu_ack   = 1'b0;
    out_ready = 1'b0;
    check("idle_ack_ignored_acc", result_o, 0);
    check("idle_ack_ignored_req", alu_req, 0);
    check("idle_ready_ignored", out_valid, 0);
    check("idle_in_ready", in_ready, 1);

    for (int t = 0; t < 7; t++) begin
      do_reduction(tbl[t].osz, rand_data(), tbl[t].dly, tbl[t].hold,
                   tbl[t].exp_err, tbl[t].exp_passes, tbl[t].exp_lat);
    end

    // Reset while the second pass of a SEW=16 reduction is pending.
    src      = rand_data();
    in_valid = 1'b1;
    in_osize = 5'b00010;
    in_src   = src;
    @(negedge clk);
    in_valid = 1'b0;
    pass     = 0;
    cyc      = 0;
    while (cyc < 50 && !(alu_req && pass == 1)) begin
      if (alu_req) begin
        alu_ack    = 1'b1;
        alu_result = rand_data();
        pass++;
      end else begin
        alu_ack = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    alu_ack = 1'b0;
    check("abort_reached_pass2", (alu_req && pass == 1), 1);
    alu_ack    = 1'b1;
    alu_result = rand_data();
    rst        = 1'b1;
    @(negedge clk);
    alu_ack = 1'b0;
    rst     = 1'b0;
    check("abort_alu_req", alu_req, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_acc_cleared", result_o, 0);
    check("abort_is_reduct_n", is_reduct_n, 1);
    check("abort_osize", osize_vector, 0);
    seen = 1'b0;
    keep = result_o;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid || alu_req) seen = 1'b1;
    end
    check("abort_no_out_valid", seen, 0);
    check("abort_acc_stable", result_o, keep);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) osz = osize_vector_t'($urandom_range(0, 31));
      else osz = osize_vector_t'(1 << $urandom_range(0, NUM - 1));
      dly  = $urandom_range(0, 3);
      hold = $urandom_range(0, 3);
      model(osz, dly, e, p, lat);
      do_reduction(osz, rand_data(), dly, hold, e, p, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
